// File: rtl/bemf_integrator.sv
`default_nettype none
// ============================================================================
// Module   : bemf_integrator
// Purpose  : Multi-channel back-EMF integrator. Accepts time-multiplexed
//            high/low ADC samples, forms the differential, removes a
//            per-channel calibration offset, applies a symmetric deadband
//            and accumulates into per-channel saturating position registers.
//            Fixed 4-cycle latency, one sample per cycle, no backpressure.
// Ports    : clk, rst_n            clock, async active-low reset
//            in_valid/in_ch        sample strobe and channel
//            adc_h/adc_l           unsigned high/low-side ADC readings
//            db_thresh             unsigned deadband magnitude
//            calib_we/ch/data      calibration offset write port
//            clr_valid/clr_ch      accumulator clear port
//            out_valid/out_ch      result strobe and channel
//            bemf_out              updated accumulator value
//            sat_flag              accumulation clamped for this result
//            vel_out               post-deadband per-sample value
//                                  (only when BEMF_VEL_OUT_EN is defined)
// Options  : `define BEMF_VEL_OUT_EN to add the vel_out port.
// Revision : 1.0 - initial release
// ============================================================================
module bemf_integrator #(
  parameter int ADC_W = 10,
  parameter int ACC_W = 36,
  parameter int NCH   = 4,
  parameter int CH_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [ADC_W-1:0]  adc_h,
  input  logic [ADC_W-1:0]  adc_l,
  input  logic [ADC_W-1:0]  db_thresh,
  input  logic              calib_we,
  input  logic [CH_W-1:0]   calib_ch,
  input  logic [ACC_W-1:0]  calib_data,
  input  logic              clr_valid,
  input  logic [CH_W-1:0]   clr_ch,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  bemf_out,
  output logic              sat_flag
`ifdef BEMF_VEL_OUT_EN
  ,
  output logic [ACC_W-1:0]  vel_out
`endif
);

  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Per-channel state
  logic [ACC_W-1:0] r_acc   [NCH];
  logic [ACC_W-1:0] r_calib [NCH];

  // Pipeline registers
  logic              r_s0_valid;
  logic [CH_W-1:0]   r_s0_ch;
  logic [ADC_W-1:0]  r_s0_h;
  logic [ADC_W-1:0]  r_s0_l;

  logic              r_s1_valid;
  logic [CH_W-1:0]   r_s1_ch;
  logic [ACC_W:0]    r_s1_d;

  logic              r_s2_valid;
  logic [CH_W-1:0]   r_s2_ch;
  logic [ACC_W-1:0]  r_s2_v;

  // ---------------------------------------------------------------- S1 ----
  logic [ADC_W:0]    w_diff;
  logic [ACC_W:0]    w_diff_ext;

  always_comb begin
    // Zero-extend both operands so the subtraction yields a proper signed
    // ADC_W+1 result, then sign-extend to the accumulator domain.
    w_diff     = {1'b0, r_s0_h} - {1'b0, r_s0_l};
    w_diff_ext = {{(ACC_W-ADC_W){w_diff[ADC_W]}}, w_diff};
  end

  // ---------------------------------------------------------------- S2 ----
  logic [ACC_W-1:0]  w_calib_sel;
  logic [ACC_W:0]    w_c_full;
  logic [ACC_W-1:0]  w_c;
  logic [ACC_W:0]    w_c_ext;
  logic [ACC_W:0]    w_c_abs;
  logic [ACC_W:0]    w_db_ext;
  logic [ACC_W-1:0]  w_v;

  always_comb begin
    // Out-of-range channels have no calibration register; treat as zero.
    w_calib_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_s1_ch == CH_W'(i)) begin
        w_calib_sel = r_calib[i];
      end
    end

    w_c_full = r_s1_d - {w_calib_sel[ACC_W-1], w_calib_sel};
    if (w_c_full[ACC_W] != w_c_full[ACC_W-1]) begin
      w_c = w_c_full[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
    end else begin
      w_c = w_c_full[ACC_W-1:0];
    end

    // Magnitude is taken one bit wider so |ACC_MIN| is representable.
    w_c_ext  = {w_c[ACC_W-1], w_c};
    w_c_abs  = w_c_ext[ACC_W] ? (~w_c_ext + 1'b1) : w_c_ext;
    w_db_ext = {{(ACC_W+1-ADC_W){1'b0}}, db_thresh};
    w_v      = (w_c_abs <= w_db_ext) ? '0 : w_c;
  end

  // ---------------------------------------------------------------- S3 ----
  logic [ACC_W-1:0]  w_acc_sel;
  logic              w_ch_ok;
  logic [ACC_W:0]    w_sum_full;
  logic              w_sum_ovf;
  logic [ACC_W-1:0]  w_sum;
  logic              w_clr_hit;

  always_comb begin
    w_acc_sel = '0;
    w_ch_ok   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_s2_ch == CH_W'(i)) begin
        w_acc_sel = r_acc[i];
        w_ch_ok   = 1'b1;
      end
    end

    w_sum_full = {w_acc_sel[ACC_W-1], w_acc_sel} + {r_s2_v[ACC_W-1], r_s2_v};
    w_sum_ovf  = w_sum_full[ACC_W] ^ w_sum_full[ACC_W-1];
    if (w_sum_ovf) begin
      w_sum = w_sum_full[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
    end else begin
      w_sum = w_sum_full[ACC_W-1:0];
    end

    // A clear landing on the channel being updated overrides the update.
    w_clr_hit = clr_valid && (clr_ch == r_s2_ch);
  end

  // ---------------------------------------------------------- pipeline ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_ch    <= '0;
      r_s0_h     <= '0;
      r_s0_l     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_d     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_ch    <= '0;
      r_s2_v     <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      bemf_out   <= '0;
      sat_flag   <= 1'b0;
`ifdef BEMF_VEL_OUT_EN
      vel_out    <= '0;
`endif
    end else begin
      r_s0_valid <= in_valid;
      r_s0_ch    <= in_ch;
      r_s0_h     <= adc_h;
      r_s0_l     <= adc_l;

      r_s1_valid <= r_s0_valid;
      r_s1_ch    <= r_s0_ch;
      r_s1_d     <= w_diff_ext;

      r_s2_valid <= r_s1_valid;
      r_s2_ch    <= r_s1_ch;
      r_s2_v     <= w_v;

      out_valid  <= r_s2_valid;
      if (r_s2_valid) begin
        out_ch <= r_s2_ch;
`ifdef BEMF_VEL_OUT_EN
        vel_out <= r_s2_v;
`endif
        if (!w_ch_ok || w_clr_hit) begin
          bemf_out <= '0;
          sat_flag <= 1'b0;
        end else begin
          bemf_out <= w_sum;
          sat_flag <= w_sum_ovf;
        end
      end
    end
  end

  // ------------------------------------------------- per-channel state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_acc[i]   <= '0;
        r_calib[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (calib_we && (calib_ch == CH_W'(i))) begin
          r_calib[i] <= calib_data;
        end
        if (clr_valid && (clr_ch == CH_W'(i))) begin
          r_acc[i] <= '0;
        end else if (r_s2_valid && (r_s2_ch == CH_W'(i))) begin
          r_acc[i] <= w_sum;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bemf_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bemf_integrator
// Purpose  : Scoreboard bench for bemf_integrator. A reference model turns
//            each stimulus edge into expected results; a monitor compares
//            every out_valid result against the expected queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bemf_integrator;

  localparam int ADC_W = 10;
  localparam int ACC_W = 36;
  localparam int NCH   = 4;
  localparam int CH_W  = 2;

  localparam longint c_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint c_MIN = -(longint'(1) <<< (ACC_W-1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [CH_W-1:0]   in_ch = '0;
  logic [ADC_W-1:0]  adc_h = '0;
  logic [ADC_W-1:0]  adc_l = '0;
  logic [ADC_W-1:0]  db_thresh = '0;
  logic              calib_we = 1'b0;
  logic [CH_W-1:0]   calib_ch = '0;
  logic [ACC_W-1:0]  calib_data = '0;
  logic              clr_valid = 1'b0;
  logic [CH_W-1:0]   clr_ch = '0;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [ACC_W-1:0]  bemf_out;
  logic              sat_flag;
`ifdef BEMF_VEL_OUT_EN
  logic [ACC_W-1:0]  vel_out;
`endif

  bemf_integrator #(
    .ADC_W(ADC_W), .ACC_W(ACC_W), .NCH(NCH), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ch(in_ch), .adc_h(adc_h), .adc_l(adc_l),
    .db_thresh(db_thresh),
    .calib_we(calib_we), .calib_ch(calib_ch), .calib_data(calib_data),
    .clr_valid(clr_valid), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ch(out_ch), .bemf_out(bemf_out),
    .sat_flag(sat_flag)
`ifdef BEMF_VEL_OUT_EN
    , .vel_out(vel_out)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int unsigned edge_cnt = 0;

  // Reference model state
  longint m_acc   [NCH];
  longint m_calib [NCH];

  typedef struct {
    int unsigned edge_n;
    int          ch;
    longint      d;
    longint      v;
  } pend_t;
  pend_t pend[$];

  typedef struct {
    int unsigned edge_n;
    int          ch;
    longint      bemf;
    bit          sat;
    longint      v;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int     ch;
    longint bemf;
    bit     sat;
  } obs_t;
  obs_t obs_q[$];

  function automatic longint clamp(input longint x, output bit sat);
    sat = 1'b0;
    if (x > c_MAX) begin sat = 1'b1; return c_MAX; end
    if (x < c_MIN) begin sat = 1'b1; return c_MIN; end
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i]   = 0;
      m_calib[i] = 0;
    end
    pend.delete();
    exp_q.delete();
  endtask

  // Effects of one rising edge, in the order the rules define them:
  // deadband decision uses calibration as it stood before this edge,
  // accumulation honours a same-edge clear, then writes land.
  task automatic model_edge();
    bit     s;
    longint c;
    longint absc;
    exp_t   e;
    pend_t  p;
    for (int k = 0; k < pend.size(); k++) begin
      if (pend[k].edge_n + 2 == edge_cnt) begin
        c    = clamp(pend[k].d - ((pend[k].ch < NCH) ? m_calib[pend[k].ch] : 0), s);
        absc = (c < 0) ? -c : c;
        pend[k].v = (absc <= longint'(db_thresh)) ? 0 : c;
      end
    end
    if (pend.size() > 0 && pend[0].edge_n + 3 == edge_cnt) begin
      p = pend.pop_front();
      e.edge_n = edge_cnt;
      e.ch     = p.ch;
      e.v      = p.v;
      if (p.ch >= NCH) begin
        e.bemf = 0; e.sat = 0;
      end else if (clr_valid && int'(clr_ch) == p.ch) begin
        e.bemf = 0; e.sat = 0;
        m_acc[p.ch] = 0;
      end else begin
        e.bemf = clamp(m_acc[p.ch] + p.v, s);
        e.sat  = s;
        m_acc[p.ch] = e.bemf;
      end
      exp_q.push_back(e);
    end
    if (calib_we && int'(calib_ch) < NCH)
      m_calib[calib_ch] = longint'($signed(calib_data));
    if (clr_valid && int'(clr_ch) < NCH)
      m_acc[clr_ch] = 0;
    if (in_valid) begin
      p.edge_n = edge_cnt;
      p.ch     = int'(in_ch);
      p.d      = longint'(adc_h) - longint'(adc_l);
      p.v      = 0;
      pend.push_back(p);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample(input int ch, input int h, input int l);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    adc_h    = ADC_W'(h);
    adc_l    = ADC_W'(l);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic write_calib(input int ch, input longint val);
    calib_we   = 1'b1;
    calib_ch   = CH_W'(ch);
    calib_data = ACC_W'(val);
    tick();
    calib_we   = 1'b0;
  endtask

  task automatic clear_ch(input int ch);
    clr_valid = 1'b1;
    clr_ch    = CH_W'(ch);
    tick();
    clr_valid = 1'b0;
  endtask

  // Directed check against constants derived by hand from the rules.
  task automatic expect_obs(input string name, input int ch, input longint bemf, input bit sat);
    obs_t o;
    tests++;
    if (obs_q.size() == 0) begin
      fails++;
      $display("FAIL %s: no result observed, required ch=%0d bemf=%0d sat=%0d", name, ch, bemf, sat);
    end else begin
      o = obs_q.pop_front();
      if (o.ch != ch || o.bemf != bemf || o.sat != sat) begin
        fails++;
        $display("FAIL %s: got ch=%0d bemf=%0d sat=%0d, required ch=%0d bemf=%0d sat=%0d",
                 name, o.ch, o.bemf, o.sat, ch, bemf, sat);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Monitor: every presented result is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    obs_t o;
    if (rst_n && out_valid) begin
      o.ch   = int'(out_ch);
      o.bemf = longint'($signed(bemf_out));
      o.sat  = sat_flag;
      obs_q.push_back(o);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: out_valid at edge %0d with ch=%0d bemf=%0d, none expected",
                 edge_cnt, out_ch, o.bemf);
      end else begin
        e = exp_q.pop_front();
        if (e.edge_n != edge_cnt || out_ch !== CH_W'(e.ch) ||
            bemf_out !== ACC_W'(e.bemf) || sat_flag !== e.sat) begin
          fails++;
          $display("FAIL scoreboard: got edge=%0d ch=%0d bemf=%0d sat=%b, required edge=%0d ch=%0d bemf=%0d sat=%0d",
                   edge_cnt, out_ch, o.bemf, sat_flag, e.edge_n, e.ch, e.bemf, e.sat);
        end
`ifdef BEMF_VEL_OUT_EN
        tests++;
        if (vel_out !== ACC_W'(e.v)) begin
          fails++;
          $display("FAIL vel_out: got %0d, required %0d", $signed(vel_out), e.v);
        end
`endif
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    ticks(2);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_sat_flag", sat_flag, 1'b0);
    tests++;
    if (bemf_out !== '0 || out_ch !== '0) begin
      fails++;
      $display("FAIL rst_outputs: got bemf=%0d ch=%0d, required 0 0", bemf_out, out_ch);
    end
    rst_n = 1'b1;
    tick();

    // Basic accumulation and latency
    db_thresh = 10'd50;
    sample(0, 600, 100);
    ticks(4);
    expect_obs("first_sample", 0, 500, 0);
    sample(0, 600, 100);
    ticks(4);
    expect_obs("second_sample", 0, 1000, 0);

    // Deadband on a fresh channel
    sample(1, 150, 100);
    sample(1, 100, 150);
    sample(1, 151, 100);
    sample(1, 100, 151);
    ticks(4);
    expect_obs("db_pos_edge", 1, 0, 0);
    expect_obs("db_neg_edge", 1, 0, 0);
    expect_obs("db_pos_out", 1, 51, 0);
    expect_obs("db_neg_out", 1, 0, 0);

    // Calibration, including a write on the edge the sample sits in S2
    db_thresh = '0;
    write_calib(2, 20);
    sample(2, 300, 100);
    ticks(4);
    expect_obs("calib_20", 2, 180, 0);
    sample(2, 300, 100);
    tick();
    write_calib(2, 1000);
    ticks(4);
    expect_obs("calib_old_used", 2, 360, 0);
    sample(2, 300, 100);
    ticks(4);
    expect_obs("calib_new_used", 2, -440, 0);
    write_calib(2, 0);

    // Interleaved back-to-back
    clear_ch(0);
    clear_ch(1);
    sample(0, 200, 100);
    sample(1, 200, 100);
    sample(0, 200, 100);
    sample(1, 200, 100);
    ticks(4);
    expect_obs("ilv_0a", 0, 100, 0);
    expect_obs("ilv_1a", 1, 100, 0);
    expect_obs("ilv_0b", 0, 200, 0);
    expect_obs("ilv_1b", 1, 200, 0);

    // Saturation: preload ch 3 through a large negative calibration
    write_calib(3, -((longint'(1) <<< 35) - 10));
    sample(3, 100, 100);
    ticks(3);
    write_calib(3, 0);
    sample(3, 200, 100);
    sample(3, 100, 200);
    ticks(4);
    expect_obs("sat_preload", 3, (longint'(1) <<< 35) - 10, 0);
    expect_obs("sat_clamp", 3, (longint'(1) <<< 35) - 1, 1);
    expect_obs("sat_release", 3, (longint'(1) <<< 35) - 101, 0);

    // Clear coincident with the S3 update of the same channel
    sample(1, 200, 100);
    ticks(2);
    clear_ch(1);
    sample(1, 105, 100);
    ticks(4);
    expect_obs("clr_collision", 1, 0, 0);
    expect_obs("clr_after", 1, 5, 0);

    // Reset with three samples in flight
    obs_q.delete();
    sample(0, 900, 100);
    sample(1, 900, 100);
    sample(2, 900, 100);
    rst_n = 1'b0;
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    ticks(5);
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL reset_inflight: got %0d results, required 0", obs_q.size());
    end
    obs_q.delete();
    for (int c = 0; c < NCH; c++) sample(c, 77, 77);
    ticks(4);
    for (int c = 0; c < NCH; c++) expect_obs("reset_acc_zero", c, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 0) db_thresh = ADC_W'($urandom_range(0, 80));
      in_valid   = ($urandom_range(0, 3) != 0);
      in_ch      = CH_W'($urandom_range(0, NCH-1));
      adc_h      = ADC_W'($urandom_range(0, 1023));
      adc_l      = ADC_W'($urandom_range(0, 1023));
      calib_we   = ($urandom_range(0, 15) == 0);
      calib_ch   = CH_W'($urandom_range(0, NCH-1));
      if ($urandom_range(0, 3) == 0)
        calib_data = ACC_W'({$urandom(), $urandom()});
      else
        calib_data = ACC_W'(longint'($urandom_range(0, 1200)) - 600);
      clr_valid  = ($urandom_range(0, 31) == 0);
      clr_ch     = CH_W'($urandom_range(0, NCH-1));
      tick();
    end
    in_valid  = 1'b0;
    calib_we  = 1'b0;
    clr_valid = 1'b0;
    ticks(6);
    tests++;
    if (exp_q.size() != 0 || pend.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d expected results outstanding, required 0", exp_q.size() + pend.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bemf_integrator.md
Name: bemf_integrator

Overview:
Multi-channel back-EMF integrator for the motor controller. Takes time-multiplexed high/low ADC samples for any of NCH motors, forms the differential, removes a per-channel calibration offset, applies a programmable symmetric deadband, and accumulates the result into per-channel position registers held inside the block. Sits between the ADC sequencer and the motor-position register file and replaces the single-stage updater, which needed an external accumulator.

Parameters:
ADC_W, 10, ADC sample width (unsigned).
ACC_W, 36, accumulator and calibration width (two's complement).
NCH, 4, number of motor channels.
CH_W, 2, channel index width; must satisfy 2^CH_W >= NCH.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  sample strobe, one sample per asserted cycle
in_ch  in  CH_W  channel of the current sample
adc_h  in  ADC_W  high-side motor ADC reading
adc_l  in  ADC_W  low-side motor ADC reading
db_thresh  in  ADC_W  deadband magnitude, unsigned, quasi-static
calib_we  in  1  calibration write strobe
calib_ch  in  CH_W  calibration target channel
calib_data  in  ACC_W  signed calibration offset
clr_valid  in  1  accumulator clear strobe
clr_ch  in  CH_W  channel to clear
out_valid  out  1  result strobe
out_ch  out  CH_W  channel of the result
bemf_out  out  ACC_W  updated accumulator value for out_ch
sat_flag  out  1  accumulation clamped this result

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: all pipeline valids, out_valid, sat_flag = 0; out_ch = 0; bemf_out = 0; all accumulators and calibration registers = 0. Reset asserted mid-operation discards in-flight samples. No out_valid follows for them.
- Fully pipelined. One sample accepted every cycle with no backpressure. Latency is fixed at 4: a sample taken at edge N produces out_valid high for the cycle after edge N+3.
- S0, capture: register adc_h, adc_l, in_ch, in_valid.
- S1, difference: d = adc_h - adc_l as ADC_W+1-bit signed, sign-extended to ACC_W+1.
- S2, calibration and deadband: c = d - calib[ch], computed in ACC_W+1 bits and clamped to the signed ACC_W range. If |c| <= db_thresh, then v = 0; otherwise v = c. The deadband is symmetric.
- S3, accumulate: s = acc[ch] + v, computed in ACC_W+1 bits. On overflow, clamp to the ACC_W max or min and set sat_flag for that result. Write acc[ch] = s and register bemf_out = s with out_ch, out_valid.
- Read-modify-write of acc happens within S3. Back-to-back samples on the same channel therefore see each other's result with no stall and no lost update.
- Calibration: calib_we writes calib[calib_ch] at the edge. A sample in S2 on that same edge uses the old value. calib_ch >= NCH is ignored.
- Clear: clr_valid zeroes acc[clr_ch] at the edge. If S3 updates the same channel on that edge, the clear wins: acc = 0, bemf_out = 0, out_valid still pulses, sat_flag = 0. clr_ch >= NCH is ignored.
- in_ch >= NCH: the sample flows through, but no accumulator is written. The result is output with bemf_out = 0 and out_valid = 1.
- Values leave the block unsigned/signed exactly as stated; no rounding or scaling.

Optional Feature:
BEMF_VEL_OUT_EN.
- Defined: adds output vel_out [ACC_W], registered alongside bemf_out, carrying the post-deadband value v (the per-sample velocity estimate). It reads 0 in reset and holds between strobes.
- Undefined: the port and its register are absent, and all other behaviour is identical.

Test Plan:
- Reset, then one sample: ch 0, adc_h = 600, adc_l = 100, calib = 0, db = 50 -> out_valid exactly 4 cycles later, out_ch = 0, bemf_out = 500. A second identical sample -> 1000.
- Deadband: calib = 0, db = 50. d = +50 -> bemf_out unchanged. d = -50 -> unchanged. d = +51 -> +51. d = -51 -> bemf_out returns to 0.
- Calibration: write calib[2] = 20. Sample ch 2 with h = 300, l = 100, db = 0 -> bemf_out = 180. calib_we on the edge the sample is in S2 -> old calib used.
- Interleaved back-to-back: ch 0, 1, 0, 1 on consecutive cycles, each d = +100, db = 0 -> outputs 100, 100, 200, 200 on consecutive cycles with correct out_ch.
- Saturation: preload ch 3 to 2^35-10 via repeated samples or force. Sample d = +100 -> bemf_out = 2^35-1, sat_flag = 1. Next negative sample clears sat_flag.
- Clear collision and reset: clr_valid ch 1 coincident with the ch 1 S3 update -> bemf_out = 0 and a later sample d = +5 gives 5. Assert rst_n low with 3 samples in flight -> no out_valid and all accumulators 0.
